instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the cpu core.
//   - Owns the program counter.
//   - Reads 32-bit instruction words from a variable-latency instruction memory using a READ/BUSYWAIT handshake.
//   - Presents each word to the core with a valid flag, and holds it while the core stalls.
//   - Applies the next-PC decision: sequential +PC_STEP, or a branch/jump target supplied by the core.

---
 rtl/instr_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage in front of the cpu core. Owns the program counter, reads one
//   instruction word at a time from a variable-latency instruction memory
//   (READ/BUSYWAIT handshake), and presents it to the core with a valid flag.
//   The word is held for as long as the core stalls. When the core accepts
//   it, the next PC is either PC+PC_STEP or a word-aligned branch target.
//
// Optional feature (macro IFETCH_TIMEOUT_EN):
//   Defined   - consecutive BUSYWAIT cycles in FETCH are counted, and once the
//               count reaches TIMEOUT_CYC the unit parks in ERR with
//               FETCH_ERR=1. Only reset leaves ERR.
//   Undefined - FETCH waits on BUSYWAIT forever and FETCH_ERR is tied 0.
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   asynchronous active-low reset
//   STALL          in   core cannot accept the next instruction (DELIVER only)
//   BRANCH_EN      in   use BRANCH_TARGET as next PC (DELIVER only)
//   BRANCH_TARGET  in   branch/jump target; low two bits are ignored
//   MEM_READ       out  instruction memory read request (registered)
//   MEM_ADDRESS    out  read address, always equal to PC
//   MEM_READDATA   in   returned instruction word
//   MEM_BUSYWAIT   in   memory not done yet
//   PC             out  address of the current or pending instruction
//   INSTRUCTION    out  fetched instruction word
//   INSTR_VALID    out  INSTRUCTION is valid for the core
//   FETCH_ERR      out  fetch timed out
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     INSTR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     PC_STEP     = 4,
  parameter int unsigned     TIMEOUT_CYC = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL,
  input  logic               BRANCH_EN,
  input  logic [PC_W-1:0]    BRANCH_TARGET,
  output logic               MEM_READ,
  output logic [PC_W-1:0]    MEM_ADDRESS,
  input  logic [INSTR_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               INSTR_VALID,
  output logic               FETCH_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DELIVER
`ifdef IFETCH_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [PC_W-1:0]      r_pc, w_pc_nxt;
  logic                 r_mem_read, w_mem_read_nxt;
  logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
  logic                 r_valid, w_valid_nxt;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0]     r_busy_cnt, w_busy_cnt_nxt, w_busy_cnt_inc;
  logic                 r_err, w_err_nxt;

  assign w_busy_cnt_inc = r_busy_cnt + CNT_W'(1);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_mem_read_nxt = r_mem_read;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_valid;
`ifdef IFETCH_TIMEOUT_EN
    w_busy_cnt_nxt = r_busy_cnt;
    w_err_nxt      = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt    = S_FETCH;
        w_mem_read_nxt = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
        w_busy_cnt_nxt = '0;
`endif
      end
      S_FETCH: begin
        if (MEM_BUSYWAIT) begin
`ifdef IFETCH_TIMEOUT_EN
          // This edge is the TIMEOUT_CYC-th consecutive busy cycle.
          if (w_busy_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
            w_state_nxt    = S_ERR;
            w_err_nxt      = 1'b1;
            w_mem_read_nxt = 1'b0;
            w_valid_nxt    = 1'b0;
          end else begin
            w_busy_cnt_nxt = w_busy_cnt_inc;
          end
`endif
        end else begin
          w_instr_nxt    = MEM_READDATA;
          w_valid_nxt    = 1'b1;
          w_mem_read_nxt = 1'b0;
          w_state_nxt    = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (!STALL) begin
          w_pc_nxt       = BRANCH_EN ? {BRANCH_TARGET[PC_W-1:2], 2'b00}
                                     : r_pc + PC_W'(PC_STEP);
          w_valid_nxt    = 1'b0;
          w_mem_read_nxt = 1'b1;
          w_state_nxt    = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
          w_busy_cnt_nxt = '0;
`endif
        end
      end
`ifdef IFETCH_TIMEOUT_EN
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
`endif
      default: begin
        w_state_nxt    = S_IDLE;
        w_mem_read_nxt = 1'b0;
        w_valid_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_mem_read <= 1'b0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_read <= w_mem_read_nxt;
      r_instr    <= w_instr_nxt;
      r_valid    <= w_valid_nxt;
`ifdef IFETCH_TIMEOUT_EN
      r_busy_cnt <= w_busy_cnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign MEM_READ    = r_mem_read;
  assign MEM_ADDRESS = r_pc;
  assign PC          = r_pc;
  assign INSTRUCTION = r_instr;
  assign INSTR_VALID = r_valid;
`ifdef IFETCH_TIMEOUT_EN
  assign FETCH_ERR   = r_err;
`else
  assign FETCH_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. The memory image is a hash of
//   the address. The reference model tracks only the architectural PC and
//   the expected timing of each instruction transaction.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;

  logic               CLK;
  logic               RESET;
  logic               STALL;
  logic               BRANCH_EN;
  logic [PC_W-1:0]    BRANCH_TARGET;
  logic               MEM_READ;
  logic [PC_W-1:0]    MEM_ADDRESS;
  logic [INSTR_W-1:0] MEM_READDATA;
  logic               MEM_BUSYWAIT;
  logic [PC_W-1:0]    PC;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               INSTR_VALID;
  logic               FETCH_ERR;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [PC_W-1:0] exp_pc;

  instr_fetch_unit #(
    .PC_W        (PC_W),
    .INSTR_W     (INSTR_W),
    .RESET_PC    (32'h0),
    .PC_STEP     (4),
    .TIMEOUT_CYC (4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_EN     (BRANCH_EN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .MEM_READ      (MEM_READ),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .PC            (PC),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_VALID   (INSTR_VALID),
    .FETCH_ERR     (FETCH_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign MEM_READDATA = mem_word(MEM_ADDRESS);

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One complete instruction: starts at a negedge with the DUT in FETCH,
  // ends at a negedge with the DUT in FETCH of the following instruction.
  task automatic test_xact(input int busy, input int stall, input bit br,
                           input logic [PC_W-1:0] tgt, input string tag);
    logic [INSTR_W-1:0] exp_instr;
    exp_instr = mem_word(exp_pc);
    for (int i = 0; i < busy; i++) begin
      MEM_BUSYWAIT = 1'b1;
      tick();
      checks++;
      if (MEM_READ !== 1'b1 || MEM_ADDRESS !== exp_pc || INSTR_VALID !== 1'b0) begin
        errors++;
        $display("FAIL %s busy: rd=%b addr=%h vld=%b, need rd=1 addr=%h vld=0",
                 tag, MEM_READ, MEM_ADDRESS, INSTR_VALID, exp_pc);
      end
    end
    MEM_BUSYWAIT = 1'b0;
    tick();
    checks++;
    if (INSTR_VALID !== 1'b1 || INSTRUCTION !== exp_instr || MEM_READ !== 1'b0 ||
        PC !== exp_pc || FETCH_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s deliver: vld=%b ins=%h rd=%b pc=%h err=%b, need vld=1 ins=%h rd=0 pc=%h err=0",
               tag, INSTR_VALID, INSTRUCTION, MEM_READ, PC, FETCH_ERR, exp_instr, exp_pc);
    end
    for (int i = 0; i < stall; i++) begin
      STALL         = 1'b1;
      BRANCH_EN     = 1'($urandom_range(1));
      BRANCH_TARGET = $urandom;
      MEM_BUSYWAIT  = 1'($urandom_range(1));
      tick();
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTRUCTION !== exp_instr || MEM_READ !== 1'b0 ||
          PC !== exp_pc) begin
        errors++;
        $display("FAIL %s stall: vld=%b ins=%h rd=%b pc=%h, need vld=1 ins=%h rd=0 pc=%h",
                 tag, INSTR_VALID, INSTRUCTION, MEM_READ, PC, exp_instr, exp_pc);
      end
    end
    STALL         = 1'b0;
    BRANCH_EN     = br;
    BRANCH_TARGET = tgt;
    MEM_BUSYWAIT  = 1'($urandom_range(1));
    tick();
    exp_pc = br ? (tgt & ~32'h3) : exp_pc + 32'd4;
    checks++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== exp_pc || PC !== exp_pc ||
        INSTR_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s next: rd=%b addr=%h pc=%h vld=%b, need rd=1 addr=%h vld=0",
               tag, MEM_READ, MEM_ADDRESS, PC, INSTR_VALID, exp_pc);
    end
    // Ignored outside DELIVER; randomise to expose any leakage.
    STALL         = 1'($urandom_range(1));
    BRANCH_EN     = 1'($urandom_range(1));
    BRANCH_TARGET = $urandom;
    MEM_BUSYWAIT  = 1'b0;
  endtask

  // Leaves the DUT at a negedge, just entered FETCH at RESET_PC.
  task automatic restart_after_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    exp_pc = 32'h0;
    checks++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 32'h0 || INSTR_VALID !== 1'b0 ||
        FETCH_ERR !== 1'b0) begin
      errors++;
      $display("FAIL %s restart: rd=%b addr=%h vld=%b err=%b, need rd=1 addr=0 vld=0 err=0",
               tag, MEM_READ, MEM_ADDRESS, INSTR_VALID, FETCH_ERR);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b0; STALL = 1'b0; BRANCH_EN = 1'b0;
    BRANCH_TARGET = '0; MEM_BUSYWAIT = 1'b0;
    #1;
    checks++;
    if (PC !== 32'h0 || MEM_READ !== 1'b0 || INSTRUCTION !== 32'h0 ||
        INSTR_VALID !== 1'b0 || FETCH_ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h rd=%b ins=%h vld=%b err=%b, need all 0",
               PC, MEM_READ, INSTRUCTION, INSTR_VALID, FETCH_ERR);
    end
    restart_after_reset("reset");
  endtask

  task automatic test_sequential;
    test_xact(0, 0, 1'b0, '0, "seq_pc0");
    test_xact(3, 0, 1'b0, '0, "busy_pc4");
  endtask

  task automatic test_stall;
    test_xact(0, 5, 1'b0, '0, "stall_pc8");
    checks++;
    if (exp_pc !== 32'd12 || MEM_ADDRESS !== 32'd12) begin
      errors++;
      $display("FAIL stall_next_addr: addr=%h, need 0000000c", MEM_ADDRESS);
    end
  endtask

  task automatic test_branch;
    test_xact(0, 0, 1'b1, 32'h23, "branch_23");
    checks++;
    if (MEM_ADDRESS !== 32'h20) begin
      errors++;
      $display("FAIL branch_align: addr=%h, need 00000020", MEM_ADDRESS);
    end
    test_xact(0, 0, 1'b0, '0, "after_branch");
    checks++;
    if (MEM_ADDRESS !== 32'h24) begin
      errors++;
      $display("FAIL branch_seq: addr=%h, need 00000024", MEM_ADDRESS);
    end
  endtask

  task automatic test_wrap;
    test_xact(0, 0, 1'b1, 32'hFFFFFFFF, "to_top");
    test_xact(0, 0, 1'b0, '0, "wrap");
    checks++;
    if (MEM_ADDRESS !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h, need 00000000", MEM_ADDRESS);
    end
  endtask

  task automatic test_reset_mid_fetch;
    test_xact(1, 0, 1'b1, 32'h1000, "pre_reset");
    MEM_BUSYWAIT = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if (MEM_READ !== 1'b0 || PC !== 32'h0 || INSTR_VALID !== 1'b0 ||
        INSTRUCTION !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: rd=%b pc=%h vld=%b ins=%h, need rd=0 pc=0 vld=0 ins=0",
               MEM_READ, PC, INSTR_VALID, INSTRUCTION);
    end
    MEM_BUSYWAIT = 1'b0;
    restart_after_reset("mid_fetch");
  endtask

  task automatic test_timeout;
    MEM_BUSYWAIT = 1'b1;
`ifdef IFETCH_TIMEOUT_EN
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (i < 4) begin
        if (FETCH_ERR !== 1'b0 || MEM_READ !== 1'b1) begin
          errors++;
          $display("FAIL timeout_pre%0d: err=%b rd=%b, need err=0 rd=1", i, FETCH_ERR, MEM_READ);
        end
      end else begin
        if (FETCH_ERR !== 1'b1 || MEM_READ !== 1'b0 || INSTR_VALID !== 1'b0) begin
          errors++;
          $display("FAIL timeout_err%0d: err=%b rd=%b vld=%b, need err=1 rd=0 vld=0",
                   i, FETCH_ERR, MEM_READ, INSTR_VALID);
        end
      end
      if (i == 4) MEM_BUSYWAIT = 1'b0;
    end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (FETCH_ERR !== 1'b0 || MEM_READ !== 1'b1 || MEM_ADDRESS !== exp_pc) begin
        errors++;
        $display("FAIL no_timeout%0d: err=%b rd=%b addr=%h, need err=0 rd=1 addr=%h",
                 i, FETCH_ERR, MEM_READ, MEM_ADDRESS, exp_pc);
      end
    end
    test_xact(0, 0, 1'b0, '0, "after_long_busy");
`endif
    MEM_BUSYWAIT = 1'b0;
    RESET = 1'b0;
    restart_after_reset("timeout");
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      test_xact(int'($urandom_range(3)), int'($urandom_range(3)),
                ($urandom_range(3) == 0), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    test_timeout();
    test_xact(0, 1, 1'b0, '0, "final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
